// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow complete on a fast path.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [4:0]       op_i,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned CNT_W   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [4:0]  OP_DIV  = 5'd16;
  localparam logic [4:0]  OP_DIVU = 5'd17;
  localparam logic [4:0]  OP_REM  = 5'd18;
  localparam logic [4:0]  OP_REMU = 5'd19;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             neg_q;
  logic             neg_r;
  logic             is_rem;

  logic             is_div_op;
  logic             op_signed;
  logic             op_rem;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             div_zero;
  logic             overflow;
  logic [WIDTH-1:0] q_spec;
  logic [WIDTH-1:0] r_spec;
  logic [WIDTH-1:0] rem_shift;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Operand decode, magnitude conversion and fast-path detection
  always_comb begin
    is_div_op = (op_i == OP_DIV) || (op_i == OP_DIVU) || (op_i == OP_REM) || (op_i == OP_REMU);
    op_signed = (op_i == OP_DIV) || (op_i == OP_REM);
    op_rem    = (op_i == OP_REM) || (op_i == OP_REMU);
    sign_a    = op_signed & operand_a[WIDTH-1];
    sign_b    = op_signed & operand_b[WIDTH-1];
    abs_a     = sign_a ? (-operand_a) : operand_a;
    abs_b     = sign_b ? (-operand_b) : operand_b;
    div_zero  = (operand_b == '0);
    overflow  = op_signed && (operand_a == {1'b1, {(WIDTH-1){1'b0}}}) && (operand_b == '1);
    q_spec    = div_zero ? '1 : {1'b1, {(WIDTH-1){1'b0}}};
    r_spec    = div_zero ? operand_a : '0;
  end

  // Restoring step: the partial remainder never has its msb set before the shift,
  // so the W-bit shifted value is exact; the trial subtract carries one guard bit.
  always_comb begin
    rem_shift = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
    diff      = {1'b0, rem_shift} - {1'b0, dvs_q};
    q_bit     = ~diff[WIDTH];
    q_fix     = neg_q ? (-quo_q) : quo_q;
    r_fix     = neg_r ? (-rem_q) : rem_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      is_rem   <= 1'b0;
      busy_o   <= 1'b0;
      valid_o  <= 1'b0;
      result_o <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && is_div_op && !flush_i) begin
            is_rem <= op_rem;
            neg_q  <= sign_a ^ sign_b;
            neg_r  <= sign_a;
            busy_o <= 1'b1;
            if (div_zero || overflow) begin
              result_o <= op_rem ? r_spec : q_spec;
              valid_o  <= 1'b1;
              state    <= DONE;
            end else begin
              dvd_q <= abs_a;
              dvs_q <= abs_b;
              quo_q <= '0;
              rem_q <= '0;
              cnt   <= CNT_W'(WIDTH - 1);
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
            quo_q <= {quo_q[WIDTH-2:0], q_bit};
            rem_q <= q_bit ? diff[WIDTH-1:0] : rem_shift;
            if (cnt == '0) state <= FIX;
            else           cnt   <= cnt - CNT_W'(1);
          end
        end
        FIX: begin
          if (flush_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            result_o <= is_rem ? r_fix : q_fix;
            valid_o  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed/unsigned results,
// fast-path corner cases, flush, mid-op reset, busy-ignore and back-to-back issue.
module tb_div_unit;

  localparam int unsigned WIDTH   = 32;
  localparam logic [4:0]  OP_ADD  = 5'd0;
  localparam logic [4:0]  OP_DIV  = 5'd16;
  localparam logic [4:0]  OP_DIVU = 5'd17;
  localparam logic [4:0]  OP_REM  = 5'd18;
  localparam logic [4:0]  OP_REMU = 5'd19;
  localparam int          SLOW    = 33;
  localparam int          FAST    = 0;

  logic             clk;
  logic             reset;
  logic             start_i;
  logic [4:0]       op_i;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             flush_i;
  logic             busy_o;
  logic             valid_o;
  logic [WIDTH-1:0] result_o;

  int checks;
  int failures;

  div_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start_i),
    .op_i      (op_i),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush_i   (flush_i),
    .busy_o    (busy_o),
    .valid_o   (valid_o),
    .result_o  (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request for one edge (the accept edge); returns in the cycle after it.
  task automatic issue(input logic [4:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start_i = 1'b1; op_i = op; operand_a = a; operand_b = b;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // lat = edges after the accept edge before valid_o is seen; busy must hold meanwhile.
  task automatic wait_valid(output int lat, output logic [WIDTH-1:0] res, output bit busy_ok);
    lat = 0; busy_ok = 1'b1;
    while (valid_o !== 1'b1 && lat < 60) begin
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (busy_o !== 1'b1) busy_ok = 1'b0;
    res = result_o;
  endtask

  task automatic do_op(input logic [4:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       output logic [WIDTH-1:0] res, output int lat, output bit busy_ok);
    issue(op, a, b);
    wait_valid(lat, res, busy_ok);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = OP_ADD; operand_a = '0; operand_b = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    checks++; if (result_o !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", result_o); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned;
    logic [WIDTH-1:0] res; int lat; bit bok;
    do_op(OP_DIVU, 32'd100, 32'd7, res, lat, bok);
    checks++; if (res !== 32'd14) begin failures++; $display("FAIL divu_100_7 got=%h exp=%h", res, 32'd14); end
    checks++; if (lat !== SLOW) begin failures++; $display("FAIL divu_latency got=%0d exp=%0d", lat, SLOW); end
    checks++; if (bok !== 1'b1) begin failures++; $display("FAIL divu_busy_held got=%b exp=1", bok); end
    checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin failures++; $display("FAIL divu_after got=busy%b/valid%b exp=0/0", busy_o, valid_o); end
    checks++; if (result_o !== 32'd14) begin failures++; $display("FAIL divu_result_hold got=%h exp=%h", result_o, 32'd14); end
    do_op(OP_REMU, 32'd100, 32'd7, res, lat, bok);
    checks++; if (res !== 32'd2) begin failures++; $display("FAIL remu_100_7 got=%h exp=%h", res, 32'd2); end
    checks++; if (lat !== SLOW) begin failures++; $display("FAIL remu_latency got=%0d exp=%0d", lat, SLOW); end
  endtask

  task automatic test_signed;
    logic [WIDTH-1:0] res; int lat; bit bok;
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, res, lat, bok);
    checks++; if (res !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_m7_2 got=%h exp=FFFFFFFD", res); end
    do_op(OP_REM, 32'hFFFF_FFF9, 32'd2, res, lat, bok);
    checks++; if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rem_m7_2 got=%h exp=FFFFFFFF", res); end
    do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, res, lat, bok);
    checks++; if (res !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_7_m2 got=%h exp=FFFFFFFD", res); end
    do_op(OP_REM, 32'd7, 32'hFFFF_FFFE, res, lat, bok);
    checks++; if (res !== 32'd1) begin failures++; $display("FAIL rem_7_m2 got=%h exp=1", res); end
    checks++; if (lat !== SLOW) begin failures++; $display("FAIL rem_signed_latency got=%0d exp=%0d", lat, SLOW); end
  endtask

  task automatic test_div_zero;
    logic [WIDTH-1:0] res; int lat; bit bok;
    do_op(OP_DIVU, 32'd5, 32'd0, res, lat, bok);
    checks++; if (res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu_by0 got=%h exp=FFFFFFFF", res); end
    checks++; if (lat !== FAST) begin failures++; $display("FAIL divu_by0_latency got=%0d exp=%0d", lat, FAST); end
    checks++; if (bok !== 1'b1) begin failures++; $display("FAIL divu_by0_busy got=%b exp=1", bok); end
    checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0) begin failures++; $display("FAIL by0_after got=busy%b/valid%b exp=0/0", busy_o, valid_o); end
    do_op(OP_REM, 32'hFFFF_FFF7, 32'd0, res, lat, bok);
    checks++; if (res !== 32'hFFFF_FFF7) begin failures++; $display("FAIL rem_by0 got=%h exp=FFFFFFF7", res); end
    checks++; if (lat !== FAST) begin failures++; $display("FAIL rem_by0_latency got=%0d exp=%0d", lat, FAST); end
  endtask

  task automatic test_overflow;
    logic [WIDTH-1:0] res; int lat; bit bok;
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bok);
    checks++; if (res !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf got=%h exp=80000000", res); end
    checks++; if (lat !== FAST) begin failures++; $display("FAIL div_ovf_latency got=%0d exp=%0d", lat, FAST); end
    do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bok);
    checks++; if (res !== 32'h0) begin failures++; $display("FAIL rem_ovf got=%h exp=0", res); end
    checks++; if (lat !== FAST) begin failures++; $display("FAIL rem_ovf_latency got=%0d exp=%0d", lat, FAST); end
    do_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bok);
    checks++; if (res !== 32'h0) begin failures++; $display("FAIL divu_big got=%h exp=0", res); end
    checks++; if (lat !== SLOW) begin failures++; $display("FAIL divu_big_latency got=%0d exp=%0d", lat, SLOW); end
    do_op(OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, res, lat, bok);
    checks++; if (res !== 32'h7FFF_FFFE) begin failures++; $display("FAIL remu_big got=%h exp=7FFFFFFE", res); end
  endtask

  task automatic test_flush;
    logic [WIDTH-1:0] res; int lat; bit bok; int seen;
    do_op(OP_DIVU, 32'd100, 32'd7, res, lat, bok);
    issue(OP_DIV, 32'd50, 32'd5);
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy_o); end
    checks++; if (result_o !== 32'd14) begin failures++; $display("FAIL flush_result got=%h exp=%h", result_o, 32'd14); end
    seen = 0;
    repeat (40) begin if (valid_o !== 1'b0) seen++; @(negedge clk); end
    checks++; if (seen !== 0) begin failures++; $display("FAIL flush_no_valid got=%0d exp=0", seen); end
    // flush together with start in IDLE must not be accepted
    flush_i = 1'b1;
    issue(OP_DIVU, 32'd9, 32'd3);
    flush_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL flush_start got=%b exp=0", busy_o); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (19) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy_o); end
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", valid_o); end
    checks++; if (result_o !== 32'h0) begin failures++; $display("FAIL rst_mid_result got=%h exp=0", result_o); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_busy_ignore;
    logic [WIDTH-1:0] res; int lat; bit bok;
    issue(OP_DIV, 32'd50, 32'd5);
    start_i = 1'b1; op_i = OP_DIVU; operand_a = 32'd9; operand_b = 32'd3;
    wait_valid(lat, res, bok);
    start_i = 1'b0;
    checks++; if (res !== 32'd10) begin failures++; $display("FAIL busy_ignore_res got=%h exp=%h", res, 32'd10); end
    checks++; if (lat !== SLOW) begin failures++; $display("FAIL busy_ignore_latency got=%0d exp=%0d", lat, SLOW); end
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL busy_ignore_idle got=%b exp=0", busy_o); end
  endtask

  task automatic test_back_to_back;
    logic [WIDTH-1:0] res; int lat; bit bok;
    issue(OP_DIVU, 32'd1000, 32'd10);
    wait_valid(lat, res, bok);
    checks++; if (res !== 32'd100) begin failures++; $display("FAIL b2b_first got=%h exp=%h", res, 32'd100); end
    start_i = 1'b1; op_i = OP_REM; operand_a = 32'hFFFF_FC18; operand_b = 32'd7;
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap got=%b exp=0", busy_o); end
    @(negedge clk);
    start_i = 1'b0;
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", busy_o); end
    wait_valid(lat, res, bok);
    checks++; if (res !== 32'hFFFF_FFFA) begin failures++; $display("FAIL b2b_second got=%h exp=FFFFFFFA", res); end
    checks++; if (lat !== SLOW) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, SLOW); end
    @(negedge clk);
  endtask

  task automatic test_non_div;
    int seen;
    issue(OP_ADD, 32'd12, 32'd3);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL add_busy got=%b exp=0", busy_o); end
    seen = 0;
    repeat (5) begin if (valid_o !== 1'b0 || busy_o !== 1'b0) seen++; @(negedge clk); end
    checks++; if (seen !== 0) begin failures++; $display("FAIL add_no_response got=%0d exp=0", seen); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_flush();
    test_reset_mid();
    test_busy_ignore();
    test_back_to_back();
    test_non_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
